pirdsp_mac_job_sequencer: RTL and testbench
===========================================

Name: pirdsp_mac_job_sequencer

Overview:
- Sequences multiply-accumulate jobs onto one shared 27x18 / SIMD-9x9 / SIMD-4x4 PIR-DSP multiplier instance.
- Accepts operand beats over a valid/ready stream, latches the job mode on the first beat and drives the multiplier operand, sign and mode pins.
- Tracks in-flight products through the multiplier's fixed latency and accumulates the returned lanes into wide accumulators.
- Presents the finished sums with an output handshake; sits between the operand-fetch logic and the multiplier.

Parameters:
MULT_LAT, 1, cycles from registered m_* drive to valid m_result_* (legal range 0..7)
ACC_W, 48, accumulator width per lane (must be >= 46)
CNT_W, 16, beat counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  operand beat valid
s_ready  out  1  sequencer can accept a beat
s_a  in  54  operand A (packing as the multiplier expects for the mode)
s_b  in  54  operand B
s_a_sign  in  1  A signed
s_b_sign  in  1  B signed
s_mode  in  2  00 = 27x18, 01 = sum 9x9, 10 = sum 4x4, 11 = illegal
s_last  in  1  final beat of the job
m_a  out  54  registered operand A to the multiplier
m_b  out  54  registered operand B to the multiplier
m_a_sign  out  1  registered
m_b_sign  out  1  registered
m_mode  out  2  registered job mode
m_result_0  in  45  multiplier lane-0 result
m_result_1  in  45  multiplier lane-1 result
o_valid  out  1  job result valid
o_ready  in  1  consumer accepts the result
o_acc_0  out  ACC_W  lane-0 accumulated sum
o_acc_1  out  ACC_W  lane-1 accumulated sum (zero in mode 00)
o_mode  out  2  mode of the completed job
o_count  out  CNT_W  beats accumulated, saturating
err  out  1  one-cycle pulse when an illegal-mode beat is consumed

Behaviour:
- Reset values: all outputs 0; state IDLE; in-flight shift register cleared; accumulators 0.
- Reset mid-job discards in-flight products with no output.
- States:
  - IDLE: s_ready = 1. The first accepted beat with a legal mode latches job_mode and goes to RUN, or to DRAIN if s_last = 1.
  - RUN: s_ready = 1. Each accepted beat is issued. An accepted beat with s_last = 1 goes to DRAIN. s_mode on non-first beats is ignored; job_mode applies.
  - DRAIN: s_ready = 0. Move to OUT the cycle after the in-flight count reaches 0 and the final accumulate has been written.
  - OUT: s_ready = 0, o_valid = 1. Outputs hold stable until o_valid & o_ready. On handshake: clear accumulators and count, go to IDLE.
- Issue: an accepted beat registers onto m_a/m_b/m_*_sign in the cycle after the handshake.
  - m_mode = job_mode throughout the job.
  - m_* hold their last value when no beat is issued.
- In-flight tracking: a valid/mode/sign shift register of depth MULT_LAT+1. The product of a beat accepted at cycle t is accumulated at the edge ending cycle t+1+MULT_LAT.
- Accumulate arithmetic:
  - signed = a_sign | b_sign of that beat; each 45-bit lane result is sign-extended if signed, else zero-extended, to ACC_W, then added.
  - Mode 00: acc_0 += result_0; acc_1 is untouched.
  - Modes 01/10: acc_0 += result_0 and acc_1 += result_1.
  - Accumulators wrap modulo 2^ACC_W.
- o_count increments per accumulated beat and saturates at 2^CNT_W - 1.
- Illegal mode (11):
  - In IDLE: the beat is consumed, not issued, err pulses, state stays IDLE.
  - In RUN: the beat is issued under job_mode (the field is ignored).
- Beat in IDLE with s_last = 1: a single-beat job, which goes straight to DRAIN.
- s_ready is a function of state only, with no dependence on s_valid; throughput is 1 beat/cycle in RUN.
- An o_ready held high before OUT has no effect.

Test Plan:
- Mode 00, unsigned, 3 beats a=5, b=7, last on beat 3, MULT_LAT=1 -> o_valid rises 4 cycles after the last handshake (issue, latency, final accumulate, enter OUT); o_acc_0=105, o_acc_1=0, o_count=3, o_mode=00.
- Mode 00, signed, a=27'h7FFFFFF (-1), b=18'd3, single beat with s_last -> o_acc_0 = -3 sign-extended (48'hFFFFFFFFFFFD); s_ready=0 from DRAIN until the output handshake.
- Mode 01, two beats with m_result_0/m_result_1 returning 100/200 then 50/-20 (signed) -> o_acc_0=150, o_acc_1=180.
- Output backpressure: o_ready=0 for 5 cycles in OUT -> outputs stable, s_ready=0, no new issue; o_ready=1 -> next cycle IDLE, accumulators 0.
- Illegal mode 11 in IDLE -> err high for exactly 1 cycle, state stays IDLE, no m_* change; a following legal job completes correctly.
- Reset asserted during DRAIN with 2 beats in flight -> no o_valid afterwards, all outputs 0; a new 1-beat job then yields only its own product.

Source files
------------

// File: rtl/pirdsp_mac_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pirdsp_mac_job_sequencer_if
// Brief    : Operand stream, multiplier pins and result stream of the MAC
//            job sequencer. The slave modport is the sequencer's view.
// Revision : 1.0 - initial release
// ============================================================================
interface pirdsp_mac_job_sequencer_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  // operand stream
  logic             s_valid;
  logic             s_ready;
  logic [53:0]      s_a;
  logic [53:0]      s_b;
  logic             s_a_sign;
  logic             s_b_sign;
  logic [1:0]       s_mode;
  logic             s_last;
  // multiplier pins
  logic [53:0]      m_a;
  logic [53:0]      m_b;
  logic             m_a_sign;
  logic             m_b_sign;
  logic [1:0]       m_mode;
  logic [44:0]      m_result_0;
  logic [44:0]      m_result_1;
  // result stream
  logic             o_valid;
  logic             o_ready;
  logic [ACC_W-1:0] o_acc_0;
  logic [ACC_W-1:0] o_acc_1;
  logic [1:0]       o_mode;
  logic [CNT_W-1:0] o_count;
  logic             err;

  modport slave (
    input  s_valid, s_a, s_b, s_a_sign, s_b_sign, s_mode, s_last,
    output s_ready,
    output m_a, m_b, m_a_sign, m_b_sign, m_mode,
    input  m_result_0, m_result_1,
    output o_valid, o_acc_0, o_acc_1, o_mode, o_count, err,
    input  o_ready
  );

  modport master (
    output s_valid, s_a, s_b, s_a_sign, s_b_sign, s_mode, s_last,
    input  s_ready,
    input  m_a, m_b, m_a_sign, m_b_sign, m_mode,
    output m_result_0, m_result_1,
    input  o_valid, o_acc_0, o_acc_1, o_mode, o_count, err,
    output o_ready
  );
endinterface
`default_nettype wire

// File: rtl/pirdsp_mac_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pirdsp_mac_job_sequencer
// Brief    : Issues MAC job beats to a shared PIR-DSP multiplier, tracks the
//            products through its latency and accumulates them per lane.
// Revision : 1.0 - initial release
// ============================================================================
module pirdsp_mac_job_sequencer #(
  parameter int MULT_LAT = 1,
  parameter int ACC_W    = 48,
  parameter int CNT_W    = 16
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  pirdsp_mac_job_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [1:0]       c_MODE_27X18   = 2'b00;
  localparam logic [1:0]       c_MODE_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
  localparam int               c_EXT_W        = ACC_W - 45;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_s_ready;
  logic             w_o_valid;
  logic             w_accept;
  logic             w_illegal;
  logic             w_issue;
  logic [1:0]       w_issue_mode;

  logic [53:0]      r_m_a;
  logic [53:0]      r_m_b;
  logic             r_m_a_sign;
  logic             r_m_b_sign;
  logic [1:0]       r_job_mode;
  logic             r_err;

  // One stage per cycle between handshake and the result being at the pins
  logic [MULT_LAT:0] r_pipe_vld;
  logic [MULT_LAT:0] r_pipe_sgn;
  logic [MULT_LAT:0] r_pipe_dual;

  logic [ACC_W-1:0] r_acc_0;
  logic [ACC_W-1:0] r_acc_1;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] w_ext_0;
  logic [ACC_W-1:0] w_ext_1;
  logic             w_lane_signed;

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_o_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && (bus.s_mode != c_MODE_ILLEGAL))
          w_state_nxt = bus.s_last ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && bus.s_last)
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty pipe means the last product was added at the previous edge
        if (r_pipe_vld == '0)
          w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_o_valid = 1'b1;
        if (bus.o_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept     = bus.s_valid & w_s_ready;
  assign w_illegal    = w_accept & (r_state == ST_IDLE) & (bus.s_mode == c_MODE_ILLEGAL);
  assign w_issue      = w_accept & ~w_illegal;
  assign w_issue_mode = (r_state == ST_IDLE) ? bus.s_mode : r_job_mode;

  assign w_lane_signed = r_pipe_sgn[MULT_LAT];
  assign w_ext_0 = w_lane_signed ? {{c_EXT_W{bus.m_result_0[44]}}, bus.m_result_0}
                                 : {{c_EXT_W{1'b0}}, bus.m_result_0};
  assign w_ext_1 = w_lane_signed ? {{c_EXT_W{bus.m_result_1[44]}}, bus.m_result_1}
                                 : {{c_EXT_W{1'b0}}, bus.m_result_1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_m_a       <= '0;
      r_m_b       <= '0;
      r_m_a_sign  <= 1'b0;
      r_m_b_sign  <= 1'b0;
      r_job_mode  <= '0;
      r_err       <= 1'b0;
      r_pipe_vld  <= '0;
      r_pipe_sgn  <= '0;
      r_pipe_dual <= '0;
      r_acc_0     <= '0;
      r_acc_1     <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_illegal;

      if (w_issue) begin
        r_m_a      <= bus.s_a;
        r_m_b      <= bus.s_b;
        r_m_a_sign <= bus.s_a_sign;
        r_m_b_sign <= bus.s_b_sign;
        r_job_mode <= w_issue_mode;
      end

      r_pipe_vld[0]  <= w_issue;
      r_pipe_sgn[0]  <= bus.s_a_sign | bus.s_b_sign;
      r_pipe_dual[0] <= (w_issue_mode != c_MODE_27X18);
      for (int i = 1; i <= MULT_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_sgn[i]  <= r_pipe_sgn[i-1];
        r_pipe_dual[i] <= r_pipe_dual[i-1];
      end

      if (r_pipe_vld[MULT_LAT]) begin
        r_acc_0 <= r_acc_0 + w_ext_0;
        if (r_pipe_dual[MULT_LAT])
          r_acc_1 <= r_acc_1 + w_ext_1;
        if (r_count != c_CNT_MAX)
          r_count <= r_count + 1'b1;
      end

      // Pipe is empty in OUT, so the clear never races an accumulate
      if ((r_state == ST_OUT) && bus.o_ready) begin
        r_acc_0 <= '0;
        r_acc_1 <= '0;
        r_count <= '0;
      end
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_a      = r_m_a;
  assign bus.m_b      = r_m_b;
  assign bus.m_a_sign = r_m_a_sign;
  assign bus.m_b_sign = r_m_b_sign;
  assign bus.m_mode   = r_job_mode;
  assign bus.o_valid  = w_o_valid;
  assign bus.o_acc_0  = r_acc_0;
  assign bus.o_acc_1  = r_acc_1;
  assign bus.o_mode   = r_job_mode;
  assign bus.o_count  = r_count;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pirdsp_mac_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pirdsp_mac_job_sequencer
// Brief    : Directed self-checking bench with a 1-cycle multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pirdsp_mac_job_sequencer;

  localparam int c_ACC_W = 48;
  localparam int c_CNT_W = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pirdsp_mac_job_sequencer_if #(.ACC_W(c_ACC_W), .CNT_W(c_CNT_W)) bus ();

  pirdsp_mac_job_sequencer #(
    .MULT_LAT (1),
    .ACC_W    (c_ACC_W),
    .CNT_W    (c_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: mode 00 is a real 27x18 product with a junk lane 1;
  // SIMD modes echo the operands as precomputed lane sums.
  logic        [44:0] mr0;
  logic        [44:0] mr1;
  logic signed [46:0] w_prod;
  assign w_prod = $signed({bus.m_a_sign & bus.m_a[26], bus.m_a[26:0]}) *
                  $signed({bus.m_b_sign & bus.m_b[17], bus.m_b[17:0]});
  always @(posedge clk) begin
    if (bus.m_mode == 2'b00) begin
      mr0 <= w_prod[44:0];
      mr1 <= 45'h123;
    end else begin
      mr0 <= bus.m_a[44:0];
      mr1 <= bus.m_b[44:0];
    end
  end
  assign bus.m_result_0 = mr0;
  assign bus.m_result_1 = mr1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [53:0] a, input logic [53:0] b, input logic as,
                      input logic bs, input logic [1:0] mode, input logic last);
    bus.s_valid  = 1'b1;
    bus.s_a      = a;
    bus.s_b      = b;
    bus.s_a_sign = as;
    bus.s_b_sign = bs;
    bus.s_mode   = mode;
    bus.s_last   = last;
    tick();
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
  endtask

  // Called in the cycle after the last handshake; cyc counts from there (=1)
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!bus.o_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!bus.o_valid) check("o_valid_timeout", 64'(bus.o_valid), 64'd1);
  endtask

  task automatic take_out();
    bus.o_ready = 1'b1;
    tick();
    bus.o_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int               cyc;
    logic             seen;
    logic [44:0]      neg20;
    logic [c_ACC_W-1:0] snap_acc;

    n_checks = 0;
    n_errors = 0;
    neg20 = -45'sd20;
    reset = 1'b1;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_a_sign = 1'b0;
    bus.s_b_sign = 1'b0; bus.s_mode = 2'b00; bus.s_last = 1'b0; bus.o_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_acc_0",   64'(bus.o_acc_0), 64'd0);
    check("rst_acc_1",   64'(bus.o_acc_1), 64'd0);
    check("rst_count",   64'(bus.o_count), 64'd0);
    check("rst_m_a",     64'(bus.m_a),     64'd0);
    check("rst_err",     64'(bus.err),     64'd0);

    // Job 1: mode 00 unsigned, middle beat carries an ignored illegal mode
    send(54'd5, 54'd7, 1'b0, 1'b0, 2'b00, 1'b0);
    send(54'd5, 54'd7, 1'b0, 1'b0, 2'b11, 1'b0);
    send(54'd5, 54'd7, 1'b0, 1'b0, 2'b00, 1'b1);
    wait_out(cyc);
    check("j1_latency", 64'(cyc),         64'd4);
    check("j1_acc_0",   64'(bus.o_acc_0), 64'd105);
    check("j1_acc_1",   64'(bus.o_acc_1), 64'd0);
    check("j1_count",   64'(bus.o_count), 64'd3);
    check("j1_mode",    64'(bus.o_mode),  64'd0);
    check("j1_m_mode",  64'(bus.m_mode),  64'd0);
    take_out();
    check("j1_done_valid", 64'(bus.o_valid), 64'd0);
    check("j1_done_acc",   64'(bus.o_acc_0), 64'd0);

    // Job 2: signed single beat, then output backpressure
    send(54'h7FFFFFF, 54'd3, 1'b1, 1'b1, 2'b00, 1'b1);
    check("j2_drain_ready", 64'(bus.s_ready), 64'd0);
    wait_out(cyc);
    check("j2_acc_0", 64'(bus.o_acc_0), 64'hFFFFFFFFFFFD);
    check("j2_count", 64'(bus.o_count), 64'd1);
    snap_acc = bus.o_acc_0;
    bus.s_valid = 1'b1; bus.s_a = 54'd999; bus.s_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",   64'(bus.o_valid), 64'd1);
      check("bp_acc_0",   64'(bus.o_acc_0), 64'(snap_acc));
      check("bp_s_ready", 64'(bus.s_ready), 64'd0);
      check("bp_m_a",     64'(bus.m_a),     64'h7FFFFFF);
    end
    bus.s_valid = 1'b0;
    take_out();
    check("bp_done_valid", 64'(bus.o_valid), 64'd0);
    check("bp_done_acc",   64'(bus.o_acc_0), 64'd0);
    check("bp_done_count", 64'(bus.o_count), 64'd0);
    check("bp_idle_ready", 64'(bus.s_ready), 64'd1);

    // Job 3: mode 01, lane sums 100/200 then 50/-20
    send(54'd100, 54'd200, 1'b1, 1'b0, 2'b01, 1'b0);
    send(54'd50, {9'd0, neg20}, 1'b1, 1'b0, 2'b01, 1'b1);
    wait_out(cyc);
    check("j3_acc_0", 64'(bus.o_acc_0), 64'd150);
    check("j3_acc_1", 64'(bus.o_acc_1), 64'd180);
    check("j3_mode",  64'(bus.o_mode),  64'd1);
    check("j3_count", 64'(bus.o_count), 64'd2);
    take_out();

    // Illegal mode in IDLE, then a legal mode-10 job
    send(54'h3FF, 54'h3FF, 1'b0, 1'b0, 2'b11, 1'b1);
    check("ill_err",     64'(bus.err),     64'd1);
    check("ill_s_ready", 64'(bus.s_ready), 64'd1);
    check("ill_m_a",     64'(bus.m_a),     64'd50);
    tick();
    check("ill_err_off", 64'(bus.err),     64'd0);
    send(54'd7, 54'd9, 1'b0, 1'b0, 2'b10, 1'b1);
    wait_out(cyc);
    check("j4_acc_0", 64'(bus.o_acc_0), 64'd7);
    check("j4_acc_1", 64'(bus.o_acc_1), 64'd9);
    check("j4_mode",  64'(bus.o_mode),  64'd2);
    take_out();

    // Reset while two products are in flight
    send(54'd3, 54'd3, 1'b0, 1'b0, 2'b00, 1'b0);
    send(54'd3, 54'd3, 1'b0, 1'b0, 2'b00, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_acc_0", 64'(bus.o_acc_0), 64'd0);
    check("mid_rst_count", 64'(bus.o_count), 64'd0);
    check("mid_rst_m_a",   64'(bus.m_a),     64'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    send(54'd4, 54'd6, 1'b0, 1'b0, 2'b00, 1'b1);
    wait_out(cyc);
    check("j5_acc_0", 64'(bus.o_acc_0), 64'd24);
    check("j5_count", 64'(bus.o_count), 64'd1);
    take_out();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
